// File: rtl/clock_period_meter.sv
// Measures the high time, low time and period of a slow square wave in clk cycles,
// and flags a stable (locked) period or a stalled input.
//
// state     | meaning
// WAIT_EDGE | idle; a rising edge starts a new measurement
// HIGH      | counting the high half-period
// LOW       | counting the low half-period; the next rise completes a period
module clock_period_meter #(
  parameter int unsigned W           = 32,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  output logic [W-1:0] high_len,
  output logic [W-1:0] low_len,
  output logic [W:0]   period,
  output logic [W-1:0] delay_est,
  output logic         duty_sym,
  output logic         valid,
  output logic         locked,
  output logic         stalled
);

  typedef enum logic [1:0] {WAIT_EDGE, HIGH, LOW} state_t;

  localparam logic [W-1:0] TO = W'(TIMEOUT);

  state_t       state;
  logic         sig_s;
  logic         prev;
  logic         rise;
  logic         fall;
  logic [W-1:0] cnt;
  logic [W-1:0] hcnt;
  logic [W:0]   prev_period;
  logic [W:0]   sum;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign sig_s = sig_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= sig_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sig_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = sig_s & ~prev;
  assign fall = ~sig_s & prev;
  assign sum  = {1'b0, hcnt} + {1'b0, cnt};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_EDGE;
      prev        <= 1'b0;
      cnt         <= '0;
      hcnt        <= '0;
      prev_period <= '0;
      high_len    <= '0;
      low_len     <= '0;
      period      <= '0;
      delay_est   <= '0;
      duty_sym    <= 1'b0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      prev  <= sig_s;
      valid <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          cnt <= '0;
          if (rise) begin
            cnt   <= W'(1);
            state <= HIGH;
          end
        end
        HIGH: begin
          // An edge wins over timeout so a half-period of exactly TIMEOUT is measured.
          if (fall) begin
            hcnt  <= cnt;
            cnt   <= W'(1);
            state <= LOW;
          end else if (cnt == TO) begin
            stalled     <= 1'b1;
            locked      <= 1'b0;
            prev_period <= '0;
            cnt         <= '0;
            state       <= WAIT_EDGE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        LOW: begin
          if (rise) begin
            high_len    <= hcnt;
            low_len     <= cnt;
            period      <= sum;
            delay_est   <= hcnt - W'(1);
            duty_sym    <= (hcnt == cnt);
            valid       <= 1'b1;
            stalled     <= 1'b0;
            locked      <= (sum == prev_period);
            prev_period <= sum;
            cnt         <= W'(1);
            state       <= HIGH;
          end else if (cnt == TO) begin
            stalled     <= 1'b1;
            locked      <= 1'b0;
            prev_period <= '0;
            cnt         <= '0;
            state       <= WAIT_EDGE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: an unsynchronized and a 2-stage synchronized
// instance share one stimulus; valid pulses are logged and compared to hand-computed values.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int W  = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W:0]   per;
    logic [W-1:0] de;
    logic         duty;
    logic         lk;
    logic         st;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;

  logic [W-1:0] hi0, lo0, de0, hi2, lo2, de2;
  logic [W:0]   per0, per2;
  logic         duty0, v0, lk0, st0, duty2, v2, lk2, st2;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   t0;
  rec_t rec0[$];
  rec_t rec2[$];
  int   cy0[$];
  int   cy2[$];

  clock_period_meter #(.W(W), .TIMEOUT(TO), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .high_len(hi0), .low_len(lo0), .period(per0), .delay_est(de0),
    .duty_sym(duty0), .valid(v0), .locked(lk0), .stalled(st0)
  );

  clock_period_meter #(.W(W), .TIMEOUT(TO), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .high_len(hi2), .low_len(lo2), .period(per2), .delay_est(de2),
    .duty_sym(duty2), .valid(v2), .locked(lk2), .stalled(st2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t snap0();
    return {hi0, lo0, per0, de0, duty0, lk0, st0};
  endfunction

  function automatic rec_t snap2();
    return {hi2, lo2, per2, de2, duty2, lk2, st2};
  endfunction

  function automatic rec_t mk(input int hi, input int lo, input int per, input int de,
                              input logic duty, input logic lk, input logic st);
    return {W'(hi), W'(lo), (W+1)'(per), W'(de), duty, lk, st};
  endfunction

  // log every valid pulse with its cycle number, 1 ns after the edge
  always @(posedge clk) begin
    #1;
    if (v0) begin
      rec0.push_back(snap0());
      cy0.push_back(cyc);
    end
    if (v2) begin
      rec2.push_back(snap2());
      cy2.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input int which, input int idx, input rec_t exp);
    rec_t r;
    int   n;
    n = (which == 0) ? rec0.size() : rec2.size();
    if (idx < n) r = (which == 0) ? rec0[idx] : rec2[idx];
    else         r = '1;
    check(tag, r, exp);
  endtask

  function automatic int cyc_of(input int which, input int idx);
    if (which == 0) return (idx < cy0.size()) ? cy0[idx] : -1;
    return (idx < cy2.size()) ? cy2[idx] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic seg(input logic val, input int n);
    sig_in = val;
    repeat (n) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick();
    check("rst_out0", snap0(), '0);
    check("rst_out2", snap2(), '0);
    check("rst_valid", {v0, v2}, 2'b00);

    // 4/4 stream: first valid at the 2nd rise, lock at the 3rd
    rst_n = 1'b1;
    t0 = cyc;
    repeat (3) begin
      seg(1'b1, 4);
      seg(1'b0, 4);
    end
    seg(1'b1, 4);
    check_rec("t1_first", 0, 0, mk(4, 4, 8, 3, 1'b1, 1'b0, 1'b0));
    check("t1_first_cyc", cyc_of(0, 0), t0 + 9);
    check_rec("t1_lock", 0, 1, mk(4, 4, 8, 3, 1'b1, 1'b1, 1'b0));
    check_rec("t1_sync_first", 2, 0, mk(4, 4, 8, 3, 1'b1, 1'b0, 1'b0));
    check_rec("t1_sync_lock", 2, 1, mk(4, 4, 8, 3, 1'b1, 1'b1, 1'b0));
    check("t1_sync_cyc0", cyc_of(2, 0), t0 + 11);
    check("t1_sync_cyc1", cyc_of(2, 1), t0 + 19);

    // 4/4 switches to 6/6
    seg(1'b0, 4);
    seg(1'b1, 6);
    seg(1'b0, 6);
    seg(1'b1, 6);
    seg(1'b0, 6);
    check_rec("t4_last44", 0, 3, mk(4, 4, 8, 3, 1'b1, 1'b1, 1'b0));
    check_rec("t4_first66", 0, 4, mk(6, 6, 12, 5, 1'b1, 1'b0, 1'b0));
    seg(1'b1, 6);
    seg(1'b0, 3);
    check_rec("t4_lock66", 0, 5, mk(6, 6, 12, 5, 1'b1, 1'b1, 1'b0));
    check("t4_count", rec0.size(), 6);

    // reset while in LOW aborts the period
    rst_n = 1'b0;
    tick();
    check("t5_rst_out0", snap0(), '0);
    check("t5_rst_out2", snap2(), '0);
    check("t5_rst_valid", {v0, v2}, 2'b00);
    rst_n = 1'b1;
    seg(1'b0, 2);
    check("t5_no_valid", rec0.size(), 6);

    // 5 high / 2 low
    repeat (3) begin
      seg(1'b1, 5);
      seg(1'b0, 2);
    end
    seg(1'b1, 1);
    check_rec("t2_first", 0, 6, mk(5, 2, 7, 4, 1'b0, 1'b0, 1'b0));
    check_rec("t2_lock", 0, 7, mk(5, 2, 7, 4, 1'b0, 1'b1, 1'b0));
    check_rec("t2_lock2", 0, 8, mk(5, 2, 7, 4, 1'b0, 1'b1, 1'b0));

    // hold high past TIMEOUT
    seg(1'b1, 15);
    check("t3_pre_stall", st0, 1'b0);
    seg(1'b1, 1);
    check("t3_stall", {st0, lk0}, 2'b10);
    check("t3_hold", {hi0, lo0, per0, de0}, {32'd5, 32'd2, 33'd7, 32'd4});
    seg(1'b1, 14);
    check("t3_no_valid", rec0.size(), 9);
    check("t3_sync_stall", st2, 1'b1);

    // resume; the first edge seen is a fall and must be ignored
    seg(1'b0, 4);
    seg(1'b1, 4);
    seg(1'b0, 4);
    check("t3_still_stall", {st0, 32'(rec0.size())}, {1'b1, 32'd9});
    seg(1'b1, 4);
    check_rec("t3_resume", 0, 9, mk(4, 4, 8, 3, 1'b1, 1'b0, 1'b0));
    seg(1'b0, 4);
    seg(1'b1, 1);
    check_rec("t3_resume_lock", 0, 10, mk(4, 4, 8, 3, 1'b1, 1'b1, 1'b0));

    // half-periods of exactly TIMEOUT are measured, not timed out
    seg(1'b1, 15);
    seg(1'b0, 16);
    seg(1'b1, 1);
    check_rec("bnd_to", 0, 11, mk(16, 16, 32, 15, 1'b1, 1'b0, 1'b0));
    check("bnd_no_stall", st0, 1'b0);

    seg(1'b1, 3);
    check("count0", rec0.size(), 12);
    check("count2", rec2.size(), 12);
    check_rec("sync_bnd_to", 2, 11, mk(16, 16, 32, 15, 1'b1, 1'b0, 1'b0));
    check("sync_bnd_cyc", cyc_of(2, 11), cyc_of(0, 11) + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
